// File: rtl/biquad_sequencer.sv
// Control FSM and datapath registers for a time-multiplexed DF-II biquad section.
// Optional macro BIQUAD_SAT_EN: saturating MAC; otherwise the MAC wraps to W bits.
module biquad_sequencer #(
  parameter int W  = 16,
  parameter int FR = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] uk_in,
  input  logic [W-1:0] muxS,
  input  logic [W-1:0] muxC,
  input  logic [W-1:0] muxZ,
  output logic [2:0]   controlS,
  output logic [1:0]   controlC,
  output logic [2:0]   controlZ,
  output logic [W-1:0] Uk,
  output logic [W-1:0] fk,
  output logic [W-1:0] fk1,
  output logic [W-1:0] fk2,
  output logic [W-1:0] yk,
  output logic [W-1:0] acum1,
  output logic [W-1:0] acum2,
  output logic [W-1:0] acum3,
  output logic         busy,
  output logic         done
);

  // state | meaning
  // IDLE  | waiting for start, captures Uk
  // M1    | acum1 = Uk    + a1*fk1
  // M2    | fk    = acum1 + a2*fk2
  // M3    | acum2 = b0*fk
  // M4    | acum3 = acum2 + b1*fk1
  // M5    | yk    = acum3 + b2*fk2
  // UPD   | shift delay line, done pulse
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_M1   = 3'd1,
    S_M2   = 3'd2,
    S_M3   = 3'd3,
    S_M4   = 3'd4,
    S_M5   = 3'd5,
    S_UPD  = 3'd6
  } state_t;

  state_t state_q, state_d;
  logic [W-1:0] uk_q, uk_d;
  logic [W-1:0] fk_q, fk_d;
  logic [W-1:0] fk1_q, fk1_d;
  logic [W-1:0] fk2_q, fk2_d;
  logic [W-1:0] yk_q, yk_d;
  logic [W-1:0] acum1_q, acum1_d;
  logic [W-1:0] acum2_q, acum2_d;
  logic [W-1:0] acum3_q, acum3_d;

  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] prod_sh;
  logic [W-1:0]          prod_w;
  logic [W:0]            sum;
  logic [W-1:0]          mac;

  // Shared MAC: floor-shifted product, range-checked to W bits, then added in W+1 bits.
  always_comb begin
    prod    = $signed({{W{muxS[W-1]}}, muxS}) * $signed({{W{muxC[W-1]}}, muxC});
    prod_sh = prod >>> FR;
`ifdef BIQUAD_SAT_EN
    if (prod_sh[2*W-1:W-1] == {(W+1){prod_sh[2*W-1]}})
      prod_w = prod_sh[W-1:0];
    else if (prod_sh[2*W-1])
      prod_w = {1'b1, {(W-1){1'b0}}};
    else
      prod_w = {1'b0, {(W-1){1'b1}}};
`else
    prod_w = prod_sh[W-1:0];
`endif
    sum = {muxZ[W-1], muxZ} + {prod_w[W-1], prod_w};
`ifdef BIQUAD_SAT_EN
    if (sum[W] == sum[W-1])
      mac = sum[W-1:0];
    else if (sum[W])
      mac = {1'b1, {(W-1){1'b0}}};
    else
      mac = {1'b0, {(W-1){1'b1}}};
`else
    mac = sum[W-1:0];
`endif
  end

`ifndef BIQUAD_SAT_EN
  logic unused_mac_bits;
  assign unused_mac_bits = ^{prod_sh[2*W-1:W], sum[W]};
`endif

  always_comb begin
    state_d = state_q;
    uk_d    = uk_q;
    fk_d    = fk_q;
    fk1_d   = fk1_q;
    fk2_d   = fk2_q;
    yk_d    = yk_q;
    acum1_d = acum1_q;
    acum2_d = acum2_q;
    acum3_d = acum3_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          uk_d    = uk_in;
          state_d = S_M1;
        end
      end
      S_M1: begin
        acum1_d = mac;
        state_d = S_M2;
      end
      S_M2: begin
        fk_d    = mac;
        state_d = S_M3;
      end
      S_M3: begin
        acum2_d = mac;
        state_d = S_M4;
      end
      S_M4: begin
        acum3_d = mac;
        state_d = S_M5;
      end
      S_M5: begin
        yk_d    = mac;
        state_d = S_UPD;
      end
      S_UPD: begin
        fk2_d   = fk1_q;
        fk1_d   = fk_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decode of the mux selects, straight from the state register.
  always_comb begin
    controlS = 3'b000;
    controlC = 2'b00;
    controlZ = 3'b000;
    case (state_q)
      S_M1: begin controlS = 3'b001; controlC = 2'b01; controlZ = 3'b001; end
      S_M2: begin controlS = 3'b010; controlC = 2'b10; controlZ = 3'b011; end
      S_M3: begin controlS = 3'b011; controlC = 2'b11; controlZ = 3'b000; end
      S_M4: begin controlS = 3'b100; controlC = 2'b01; controlZ = 3'b100; end
      S_M5: begin controlS = 3'b101; controlC = 2'b10; controlZ = 3'b101; end
      default: begin controlS = 3'b000; controlC = 2'b00; controlZ = 3'b000; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      uk_q    <= '0;
      fk_q    <= '0;
      fk1_q   <= '0;
      fk2_q   <= '0;
      yk_q    <= '0;
      acum1_q <= '0;
      acum2_q <= '0;
      acum3_q <= '0;
    end else begin
      state_q <= state_d;
      uk_q    <= uk_d;
      fk_q    <= fk_d;
      fk1_q   <= fk1_d;
      fk2_q   <= fk2_d;
      yk_q    <= yk_d;
      acum1_q <= acum1_d;
      acum2_q <= acum2_d;
      acum3_q <= acum3_d;
    end
  end

  assign Uk    = uk_q;
  assign fk    = fk_q;
  assign fk1   = fk1_q;
  assign fk2   = fk2_q;
  assign yk    = yk_q;
  assign acum1 = acum1_q;
  assign acum2 = acum2_q;
  assign acum3 = acum3_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_UPD);

endmodule
